// File: rtl/cpu16_pkg.sv
// cpu16_pkg: shared field widths, bit positions, immediate range and format enum
// for the 16-bit instruction word.
package cpu16_pkg;
    localparam int OPC_W  = 3;
    localparam int REG_W  = 3;
    localparam int OPC_HI = 15;
    localparam int OPC_LO = 13;
    localparam int R1_HI  = 12;
    localparam int R1_LO  = 10;
    localparam int R2_HI  = 9;
    localparam int R2_LO  = 7;
    localparam int R3_HI  = 6;
    localparam int R3_LO  = 4;
    localparam int IMM_HI = 6;
    localparam int IMM_LO = 0;
    localparam int IMM_MIN = -64;
    localparam int IMM_MAX = 63;

    typedef enum logic {FMT_R = 1'b0, FMT_I = 1'b1} fmt_e;

    // R-type leaves the low nibble zero; I-type keeps only the low 7 immediate bits.
    function automatic logic [15:0] pack_instr(
        input logic [OPC_W-1:0] op,
        input logic [REG_W-1:0] r1,
        input logic [REG_W-1:0] r2,
        input logic [REG_W-1:0] r3,
        input fmt_e             fmt,
        input logic [15:0]      imm
    );
        logic [15:0] w;
        w = '0;
        w[OPC_HI:OPC_LO] = op;
        w[R1_HI:R1_LO]   = r1;
        w[R2_HI:R2_LO]   = r2;
        if (fmt == FMT_I) w[IMM_HI:IMM_LO] = imm[IMM_HI:IMM_LO];
        else              w[R3_HI:R3_LO]   = r3;
        return w;
    endfunction
endpackage

// File: rtl/instruction_encoder_if.sv
// instruction_encoder_if: field-side and decoder-side handshakes plus status
// of the instruction encoder; master drives fields, slave is the encoder.
interface instruction_encoder_if #(parameter int DEPTH = 4);
    localparam int CW = $clog2(DEPTH + 1);
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_opcode;
    logic [2:0]    in_reg1;
    logic [2:0]    in_reg2;
    logic [2:0]    in_reg3;
    logic          in_fmt;
    logic [15:0]   in_imm;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   out_instr;
    logic [CW-1:0] count;
    logic          imm_err;

    modport master (
        output flush, in_valid, in_opcode, in_reg1, in_reg2, in_reg3, in_fmt, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, count, imm_err
    );
    modport slave (
        input  flush, in_valid, in_opcode, in_reg1, in_reg2, in_reg3, in_fmt, in_imm, out_ready,
        output in_ready, out_valid, out_instr, count, imm_err
    );
endinterface

// File: rtl/instruction_encoder_instr_fifo.sv
// instr_fifo: DEPTH x 16 word queue with occupancy count and synchronous flush;
// storage is reset so the head reads 16'h0000 after reset.
module instr_fifo #(
    parameter  int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [15:0]   data_i,
    input  logic          pop_i,
    output logic [15:0]   data_o,
    output logic          valid_o,
    output logic          ready_o,
    output logic [CW-1:0] count_o
);
    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_en, rd_en;

    // No pass-through when full: a same-cycle pop does not open the input.
    assign ready_o = cnt_q < CW'(DEPTH);
    assign valid_o = cnt_q != '0;
    assign wr_en   = push_i && ready_o;
    assign rd_en   = pop_i && valid_o;
    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    always_comb begin
        wr_d  = flush_i ? '0 : wr_q + AW'(wr_en);
        rd_d  = flush_i ? '0 : rd_q + AW'(rd_en);
        cnt_d = flush_i ? '0 : cnt_q + CW'(wr_en) - CW'(rd_en);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (wr_en && !flush_i) mem_q[wr_q] <= data_i;
        end
    end
endmodule

// File: rtl/instruction_encoder.sv
// instruction_encoder: packs opcode/register/immediate fields into 16-bit words
// and queues them for the decoder; IMM_RANGE_CHECK_EN enables the immediate range check.
module instruction_encoder
    import cpu16_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    instruction_encoder_if.slave bus
);
    logic        accept, range_err, push;
    logic [15:0] word;

    assign accept = bus.in_valid && bus.in_ready;
    assign word   = pack_instr(bus.in_opcode, bus.in_reg1, bus.in_reg2, bus.in_reg3,
                               fmt_e'(bus.in_fmt), bus.in_imm);

`ifdef IMM_RANGE_CHECK_EN
    logic imm_err_q, imm_err_d;

    assign range_err = (fmt_e'(bus.in_fmt) == FMT_I) &&
                       (int'($signed(bus.in_imm)) < IMM_MIN || int'($signed(bus.in_imm)) > IMM_MAX);
    // A flush discards the input, so a rejected immediate under flush is not reported.
    assign imm_err_d = accept && range_err && !bus.flush;
    assign bus.imm_err = imm_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) imm_err_q <= 1'b0;
        else        imm_err_q <= imm_err_d;
    end
`else
    assign range_err   = 1'b0;
    assign bus.imm_err = 1'b0;
`endif

    assign push = accept && !range_err;

    instr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (bus.flush),
        .push_i  (push),
        .data_i  (word),
        .pop_i   (bus.out_ready),
        .data_o  (bus.out_instr),
        .valid_o (bus.out_valid),
        .ready_o (bus.in_ready),
        .count_o (bus.count)
    );
endmodule

// File: tb/tb_instruction_encoder.sv
// tb_instruction_encoder: directed and randomized stimulus with a queue-based
// reference model; a negedge monitor compares every DUT output against it.
module tb_instruction_encoder;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_q[$];
    bit   err_exp = 1'b0;

    always #5 clk = ~clk;

    instruction_encoder_if #(.DEPTH(DEPTH)) bus ();
    instruction_encoder #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference word built from field weights rather than bit slicing.
    function automatic int ref_word(int op, int r1, int r2, int r3, int fmt, int imm);
        return op * 8192 + r1 * 1024 + r2 * 128 + (fmt != 0 ? (imm & 127) : r3 * 16);
    endfunction

    function automatic bit ref_bad(int fmt, int imm);
`ifdef IMM_RANGE_CHECK_EN
        return fmt != 0 && (imm < -64 || imm > 63);
`else
        return 1'b0;
`endif
    endfunction

    // Inputs change only at posedge+1, so values seen here are those of the next edge.
    always @(negedge clk) begin
        if (rst_n) begin
            int  imm;
            bit  acc, pop, bad;
            check("count", int'(bus.count), exp_q.size());
            check("in_ready", int'(bus.in_ready), int'(exp_q.size() < DEPTH));
            check("out_valid", int'(bus.out_valid), int'(exp_q.size() > 0));
            if (exp_q.size() > 0) check("out_instr", int'(bus.out_instr), exp_q[0]);
            check("imm_err", int'(bus.imm_err), int'(err_exp));
            imm = int'($signed(bus.in_imm));
            acc = bus.in_valid && exp_q.size() < DEPTH;
            pop = bus.out_ready && exp_q.size() > 0;
            bad = ref_bad(int'(bus.in_fmt), imm);
            err_exp = acc && bad && !bus.flush;
            if (bus.flush) exp_q.delete();
            else begin
                if (pop) void'(exp_q.pop_front());
                if (acc && !bad)
                    exp_q.push_back(ref_word(int'(bus.in_opcode), int'(bus.in_reg1), int'(bus.in_reg2),
                                             int'(bus.in_reg3), int'(bus.in_fmt), imm));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int op, input int r1, input int r2, input int r3, input int fmt, input int imm);
        bus.in_opcode = 3'(op);
        bus.in_reg1   = 3'(r1);
        bus.in_reg2   = 3'(r2);
        bus.in_reg3   = 3'(r3);
        bus.in_fmt    = 1'(fmt);
        bus.in_imm    = 16'(imm);
    endtask

    task automatic push_one(input int op, input int r1, input int r2, input int r3, input int fmt, input int imm);
        set_in(op, r1, r2, r3, fmt, imm);
        bus.in_valid = 1'b1;
        cyc();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        repeat (DEPTH + 1) cyc();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        set_in(0, 0, 0, 0, 0, 0);
        #2;
        check("reset_count", int'(bus.count), 0);
        check("reset_out_valid", int'(bus.out_valid), 0);
        check("reset_out_instr", int'(bus.out_instr), 0);
        check("reset_imm_err", int'(bus.imm_err), 0);
        #10 rst_n = 1'b1;
        cyc();
        check("in_ready_after_reset", int'(bus.in_ready), 1);

        push_one(3'b010, 1, 2, 3, 0, 0);
        check("r_type_valid", int'(bus.out_valid), 1);
        check("r_type_word", int'(bus.out_instr), 16'h4530);
        drain();

        push_one(3'b101, 7, 0, 0, 1, -1);
        w = bus.out_instr;
        check("i_type_word", int'(w), 16'hBC7F);
        check("i_type_sext", int'({{9{w[6]}}, w[6:0]}), 16'hFFFF);
        drain();

        for (int i = 0; i < 5; i++) begin
            push_one(i, i + 1, i + 2, i + 3, 0, 0);
            if (i == 3) begin
                check("full_count", int'(bus.count), 4);
                check("full_in_ready", int'(bus.in_ready), 0);
            end
        end
        check("fifth_not_taken", int'(bus.count), 4);
        drain();
        check("drained", int'(bus.count), 0);

        push_one(1, 2, 3, 0, 1, 64);
`ifdef IMM_RANGE_CHECK_EN
        check("imm_err_pulse", int'(bus.imm_err), 1);
        check("imm_err_count", int'(bus.count), 0);
        cyc();
        check("imm_err_one_cycle", int'(bus.imm_err), 0);
`else
        check("imm_trunc_count", int'(bus.count), 1);
        w = bus.out_instr;
        check("imm_trunc_low", int'(w[6:0]), 7'h40);
`endif
        drain();

        for (int i = 0; i < 3; i++) push_one(i, i, i, i, 0, 0);
        check("pre_flush_count", int'(bus.count), 3);
        set_in(7, 7, 7, 7, 0, 0);
        bus.flush = 1'b1;
        bus.in_valid = 1'b1;
        cyc();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_count", int'(bus.count), 0);
        check("flush_out_valid", int'(bus.out_valid), 0);

        push_one(2, 3, 4, 5, 0, 0);
        push_one(6, 5, 4, 0, 1, 21);
        check("pre_reset_count", int'(bus.count), 2);
        #2 rst_n = 1'b0;
        #1;
        check("async_count", int'(bus.count), 0);
        check("async_out_valid", int'(bus.out_valid), 0);
        check("async_out_instr", int'(bus.out_instr), 0);
        check("async_imm_err", int'(bus.imm_err), 0);
        exp_q.delete();
        err_exp = 1'b0;
        cyc();
        #2 rst_n = 1'b1;
        cyc();

        for (int i = 0; i < 600; i++) begin
            int imm;
            imm = ($urandom_range(0, 3) == 0) ? int'($signed(16'($urandom))) : int'($urandom_range(0, 160)) - 80;
            set_in(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 1)), imm);
            bus.in_valid  = $urandom_range(0, 2) != 0;
            bus.out_ready = $urandom_range(0, 2) == 0;
            bus.flush     = $urandom_range(0, 40) == 0;
            cyc();
        end
        bus.in_valid = 1'b0;
        bus.flush = 1'b0;
        drain();
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/instruction_encoder.md
INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, output queue depth in words (power of two, >=2).
REQ-002 SHALL have ports `clk` (input, 1): the single clock, rising edge.
REQ-003 SHALL have port `rst_n` (input, 1): reset, asynchronous and active-low.
REQ-004 SHALL have port `flush` (input, 1): synchronous queue clear.
REQ-005 SHALL have ports `in_valid` (input, 1) and `in_ready` (output, 1): field-side handshake.
REQ-006 SHALL have ports `in_opcode` (input, 3), `in_reg1` (input, 3), `in_reg2` (input, 3), `in_reg3` (input, 3), `in_fmt` (input, 1, 0=R-type, 1=I-type) and `in_imm` (input, 16, signed).
REQ-007 SHALL have ports `out_valid` (output, 1), `out_ready` (input, 1) and `out_instr` (output, 16): decoder-side handshake.
REQ-008 SHALL have ports `count` (output, clog2(DEPTH+1)): queue occupancy, and `imm_err` (output, 1): range-error pulse.

Function
REQ-009 SHALL accept a field set on any rising `clk` edge with `in_valid` && `in_ready`.
REQ-010 SHALL pack the 16-bit word as follows:
- [15:13] opcode
- [12:10] reg1
- [9:7] reg2
- [6:0] for R-type: {reg3, 4'b0000}
- [6:0] for I-type: in_imm[6:0]
REQ-011 SHALL drive `in_ready` = (count < DEPTH); there is no pass-through when full, even if a pop occurs in the same cycle.
REQ-012 SHALL present an accepted word on `out_instr` with `out_valid`=1 starting the cycle after acceptance (1-cycle latency when empty).
REQ-013 SHALL drive `out_valid` = (count > 0) and hold `out_instr` stable while `out_valid` && !`out_ready`.
REQ-014 SHALL pop the head word on `out_valid` && `out_ready`, preserving FIFO order.
REQ-015 SHALL, on simultaneous push and pop, leave `count` unchanged; read and write pointers wrap modulo DEPTH.
REQ-016 SHALL not change state on a pop while empty or on `in_valid` while full.
REQ-017 SHALL give `flush` priority over push and pop: it sets count=0, resets pointers and discards any concurrent input (the input handshake still completes).
REQ-018 SHALL treat `out_instr` as don't-care while `out_valid`=0; it drives 16'h0000 after reset.

Reset
REQ-019 SHALL, on `rst_n` low, asynchronously clear:
- count=0
- pointers=0
- out_valid=0
- imm_err=0
- out_instr=16'h0000
REQ-020 SHALL drive in_ready=1 from the first edge after deassertion; a reset mid-transfer drops all queued words.

Configuration
REQ-021 SHALL, with macro IMM_RANGE_CHECK_EN defined, treat an I-type accept with in_imm outside -64..63 as a range error.
REQ-022 SHALL, on such a range error:
- consume the handshake
- not enqueue the word
- pulse imm_err for exactly one cycle after the accept edge
REQ-023 SHALL, without IMM_RANGE_CHECK_EN, truncate in_imm to [6:0], always enqueue, and tie imm_err to 0.

Structure
REQ-024 SHALL take the following constants from shared package cpu16_pkg:
- opcode and register field widths
- field bit positions (15:13, 12:10, 9:7, 6:4, 6:0)
- IMM_MIN=-64 and IMM_MAX=63
- fmt enum {FMT_R, FMT_I}
REQ-025 SHALL place storage in one sub-module, instr_fifo (DEPTH x 16, count, pointers, flush); packing and range check stay in instruction_encoder.

Verification
REQ-026 SHALL cover: R-type opcode=3'b010, reg1=1, reg2=2, reg3=3 -> out_instr=16'h4530 one cycle after accept.
REQ-027 SHALL cover: I-type opcode=3'b101, reg1=7, reg2=0, imm=-1 -> out_instr=16'hBC7F; the decoder re-extends this to 16'hFFFF.
REQ-028 SHALL cover: 5 pushes with out_ready=0 and DEPTH=4 -> in_ready=0 after the 4th push, count=4, the 5th word is not taken; then out_ready=1 -> the 4 words drain in order.
REQ-029 SHALL cover, with IMM_RANGE_CHECK_EN: I-type imm=64 -> imm_err=1 for one cycle, count unchanged; without the macro -> word [6:0]=7'h40 enqueued.
REQ-030 SHALL cover: flush asserted with count=3 and a concurrent push -> next cycle count=0, out_valid=0.
REQ-031 SHALL cover: rst_n pulsed low mid-stream with count=2 -> outputs clear immediately, without waiting for a clock edge.
